// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IFU/LSU memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single core memory bus between the fetch unit (IFU) and the
// load/store unit (LSU). One transaction in flight at a time; the LSU wins
// ties unless it has already taken MAX_LSU_STREAK grants while the IFU waits.
// Fetch responses hit by a pipeline redirect are consumed but not forwarded.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  // fetch port
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  // load/store port
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  // downstream bus
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_wen,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_resp_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int STRK_W = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_LSU_STREAK);

  // Control state
  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STRK_W-1:0]   streak_q, streak_d;
  logic                drop_q, drop_d;

  // Latched request fields; only visible on the bus while in ST_REQ
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;

  logic ifu_eligible;
  logic streak_full;
  logic grant_lsu;
  logic grant_ifu;
  logic resp_fire;
  logic in_req;

  // Grant decision, only meaningful in IDLE; a redirect blocks any IFU grant
  always_comb begin
    ifu_eligible = ifu_req_valid & ~flush;
    streak_full  = (streak_q == STRK_MAX);
    grant_lsu    = 1'b0;
    grant_ifu    = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_lsu = lsu_req_valid & ~(streak_full & ifu_eligible);
      grant_ifu = ~grant_lsu & ifu_eligible;
    end
  end

  // Next-state: FSM, owner, streak, drop flag and request latch
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    drop_d   = drop_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (grant_lsu) begin
          state_d  = ST_REQ;
          owner_d  = OWNER_LSU;
          streak_d = streak_full ? streak_q : streak_q + STRK_W'(1);
          addr_d   = lsu_addr;
          wen_d    = lsu_wen;
          wdata_d  = lsu_wdata;
          wmask_d  = lsu_wmask;
        end else if (grant_ifu) begin
          state_d  = ST_REQ;
          owner_d  = OWNER_IFU;
          streak_d = '0;
          addr_d   = ifu_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
        end
      end
      ST_REQ: begin
        // An issued request always completes; a redirect only marks it stale
        if (flush && owner_q == OWNER_IFU) drop_d = 1'b1;
        if (bus_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (flush && owner_q == OWNER_IFU) drop_d = 1'b1;
        if (bus_resp_valid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_IFU;
      streak_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
    end
  end

  // Request field latch; outputs are gated by state so no reset is needed
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wen_q   <= wen_d;
    wdata_q <= wdata_d;
    wmask_q <= wmask_d;
  end

  // Output drive: readies, bus request fields and response routing
  always_comb begin
    in_req         = (state_q == ST_REQ);
    resp_fire      = (state_q == ST_RESP) & bus_resp_valid;
    ifu_req_ready  = grant_ifu & ~reset;
    lsu_req_ready  = grant_lsu & ~reset;
    bus_req_valid  = in_req;
    bus_addr       = in_req ? addr_q  : '0;
    bus_wen        = in_req & wen_q;
    bus_wdata      = in_req ? wdata_q : '0;
    bus_wmask      = in_req ? wmask_q : '0;
    // A redirect in the response cycle itself also suppresses the fetch data
    ifu_resp_valid = resp_fire & (owner_q == OWNER_IFU) & ~drop_q & ~flush;
    lsu_resp_valid = resp_fire & (owner_q == OWNER_LSU);
    ifu_rdata      = ifu_resp_valid ? bus_rdata : '0;
    ifu_resp_err   = ifu_resp_valid & bus_resp_err;
    lsu_rdata      = lsu_resp_valid ? bus_rdata : '0;
    lsu_resp_err   = lsu_resp_valid & bus_resp_err;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized
// transaction loop checked against a grant/streak reference model.
module tb_mem_bus_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MW   = DW / 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_resp_err;
  logic          lsu_req_valid, lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_resp_err;
  logic          bus_req_valid, bus_req_ready;
  logic [AW-1:0] bus_addr;
  logic          bus_wen;
  logic [DW-1:0] bus_wdata;
  logic [MW-1:0] bus_wmask;
  logic          bus_resp_valid;
  logic [DW-1:0] bus_rdata;
  logic          bus_resp_err;

  int checks   = 0;
  int failures = 0;
  // Reference model: LSU grants since the last IFU grant, capped at MAXS
  int lsu_run  = 0;

  logic [139:0] all_out;
  assign all_out = {ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
                    lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
                    bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask};

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LSU_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
  );

  // Expected winner in an idle cycle: 0 none, 1 IFU, 2 LSU
  function automatic int pick(bit iv, bit lv, bit fl);
    if (lv && !(lsu_run >= MAXS && iv && !fl)) return 2;
    if (iv && !fl) return 1;
    return 0;
  endfunction

  function automatic void note_grant(int who);
    if (who == 2) lsu_run = (lsu_run < MAXS) ? lsu_run + 1 : MAXS;
    else if (who == 1) lsu_run = 0;
  endfunction

  task automatic drive_quiet();
    flush = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0; bus_resp_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_quiet();
    repeat (2) @(negedge clk);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; bus_resp_valid = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready: got %b required 00", {ifu_req_ready, lsu_req_ready});
    end
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_quiet();
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL post_reset_idle: got %h required 0", all_out);
    end
    lsu_run = 0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; bus_req_ready = 1'b1;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      failures++; $display("FAIL fetch_grant: got %b required 10", {ifu_req_ready, lsu_req_ready});
    end
    note_grant(1);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    checks++;
    if (bus_req_valid !== 1'b1 || bus_addr !== 32'h8000_0000 || bus_wen !== 1'b0 || bus_wmask !== 4'h0 || bus_wdata !== '0) begin
      failures++; $display("FAIL fetch_bus: got v=%b a=%h w=%b m=%h required v=1 a=80000000 w=0 m=0",
                           bus_req_valid, bus_addr, bus_wen, bus_wmask);
    end
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'h0000_0413;
    #1;
    checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || lsu_resp_valid !== 1'b0 || bus_req_valid !== 1'b0) begin
      failures++; $display("FAIL fetch_resp: got iv=%b d=%h lv=%b bv=%b required 1 00000413 0 0",
                           ifu_resp_valid, ifu_rdata, lsu_resp_valid, bus_req_valid);
    end
    @(negedge clk);
    bus_resp_valid = 1'b0;
    #1;
    checks++;
    if (ifu_resp_valid !== 1'b0 || ifu_rdata !== '0) begin
      failures++; $display("FAIL fetch_resp_off: got v=%b d=%h required 0 0", ifu_resp_valid, ifu_rdata);
    end
  endtask

  task automatic test_priority();
    int exp;
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    #1;
    exp = pick(1'b1, 1'b1, 1'b0);
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== {exp == 1, exp == 2}) begin
      failures++; $display("FAIL prio_grant: got %b required %b", {ifu_req_ready, lsu_req_ready}, {exp == 1, exp == 2});
    end
    note_grant(exp);
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; bus_req_ready = 1'b1;
    #1;
    checks++;
    if (bus_req_valid !== 1'b1 || bus_addr !== 32'h0000_1000 || bus_wen !== 1'b1 ||
        bus_wdata !== 32'hDEAD_BEEF || bus_wmask !== 4'hF) begin
      failures++; $display("FAIL prio_bus: got v=%b a=%h w=%b d=%h m=%h required 1 00001000 1 deadbeef f",
                           bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask);
    end
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'h0; bus_resp_err = 1'b1;
    #1;
    checks++;
    if (lsu_resp_valid !== 1'b1 || lsu_resp_err !== 1'b1 || ifu_resp_valid !== 1'b0 || ifu_resp_err !== 1'b0) begin
      failures++; $display("FAIL prio_resp: got lv=%b le=%b iv=%b ie=%b required 1 1 0 0",
                           lsu_resp_valid, lsu_resp_err, ifu_resp_valid, ifu_resp_err);
    end
    @(negedge clk);
    drive_quiet();
  endtask

  task automatic test_fairness();
    int grants, last, cyc, exp, got;
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    lsu_run = 0;
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0200; lsu_wen = 1'b0;
    bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_rdata = 32'h0000_0013;
    grants = 0; last = -1; cyc = 0;
    while (grants < 12 && cyc < 60) begin
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        exp = pick(1'b1, 1'b1, 1'b0);
        got = ifu_req_ready ? (lsu_req_ready ? 3 : 1) : 2;
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL fair_order[%0d]: got %0d required %0d (1=IFU 2=LSU)", grants, got, exp);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 3) begin
            failures++; $display("FAIL fair_spacing[%0d]: got %0d cycles required 3", grants, cyc - last);
          end
        end
        note_grant(exp);
        last = cyc;
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (grants != 12) begin
      failures++; $display("FAIL fair_timeout: got %0d grants required 12", grants);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    drive_quiet();
  endtask

  task automatic test_flush_drop();
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      failures++; $display("FAIL drop_grant: got %b required 1", ifu_req_ready);
    end
    note_grant(1);
    @(negedge clk);
    ifu_req_valid = 1'b0; bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (ifu_resp_valid !== 1'b0 || ifu_rdata !== '0 || lsu_resp_valid !== 1'b0) begin
      failures++; $display("FAIL drop_suppress: got iv=%b d=%h lv=%b required 0 0 0", ifu_resp_valid, ifu_rdata, lsu_resp_valid);
    end
    @(negedge clk);
    bus_resp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      failures++; $display("FAIL drop_regrant: got %b required 1", ifu_req_ready);
    end
    note_grant(1);
    @(negedge clk);
    ifu_req_valid = 1'b0; bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'h0000_0297;
    #1;
    checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0297) begin
      failures++; $display("FAIL drop_next_resp: got v=%b d=%h required 1 00000297", ifu_resp_valid, ifu_rdata);
    end
    @(negedge clk);
    drive_quiet();
  endtask

  task automatic test_stall();
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2040; lsu_wen = 1'b0;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      failures++; $display("FAIL stall_grant: got %b required 1", lsu_req_ready);
    end
    note_grant(2);
    @(negedge clk);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; bus_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus_req_valid !== 1'b1 || bus_addr !== 32'h0000_2040 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d]: got v=%b a=%h rdy=%b%b required 1 00002040 00",
                             i, bus_req_valid, bus_addr, ifu_req_ready, lsu_req_ready);
      end
      @(negedge clk);
    end
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    checks++;
    if (bus_req_valid !== 1'b0 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
      failures++; $display("FAIL stall_resp_wait: got v=%b rdy=%b%b required 0 00", bus_req_valid, ifu_req_ready, lsu_req_ready);
    end
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'h5A5A_0001;
    #1;
    checks++;
    if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 32'h5A5A_0001) begin
      failures++; $display("FAIL stall_resp: got v=%b d=%h required 1 5a5a0001", lsu_resp_valid, lsu_rdata);
    end
    @(negedge clk);
    drive_quiet();
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      bit iv, lv, fl, wen, ewen, dropped, err, exp_iv, exp_lv;
      int who, rw, sw;
      logic [AW-1:0] ia, la, ea;
      logic [DW-1:0] wd, ewd, rd;
      logic [MW-1:0] wm, ewm;
      iv  = ($urandom_range(0, 3) != 0);
      lv  = ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 7) == 0);
      wen = ($urandom_range(0, 1) == 1);
      ia = $urandom; la = $urandom; wd = $urandom; wm = MW'($urandom);
      @(negedge clk);
      ifu_req_valid = iv; ifu_addr = ia; flush = fl;
      lsu_req_valid = lv; lsu_addr = la; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
      #1;
      who = pick(iv, lv, fl);
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {who == 1, who == 2}) begin
        failures++; $display("FAIL rand_grant[%0d]: got %b required %b (iv=%b lv=%b fl=%b run=%0d)",
                             t, {ifu_req_ready, lsu_req_ready}, {who == 1, who == 2}, iv, lv, fl, lsu_run);
      end
      note_grant(who);
      if (who == 0) begin
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (bus_req_valid !== 1'b0) begin
          failures++; $display("FAIL rand_nogrant[%0d]: got bus_req_valid=%b required 0", t, bus_req_valid);
        end
        continue;
      end
      if (who == 2) begin
        ea = la; ewen = wen; ewd = wd; ewm = wm;
      end else begin
        ea = ia; ewen = 1'b0; ewd = '0; ewm = '0;
      end
      dropped = 1'b0;
      rw = $urandom_range(0, 3);
      for (int c = 0; c <= rw; c++) begin
        @(negedge clk);
        ifu_req_valid = ($urandom_range(0, 1) == 1);
        lsu_req_valid = ($urandom_range(0, 1) == 1);
        bus_req_ready = (c == rw);
        flush = ($urandom_range(0, 5) == 0);
        bus_resp_valid = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
        if (flush && who == 1) dropped = 1'b1;
        #1;
        checks++;
        if (bus_req_valid !== 1'b1 || bus_addr !== ea || bus_wen !== ewen || bus_wdata !== ewd || bus_wmask !== ewm) begin
          failures++; $display("FAIL rand_busreq[%0d]: got v=%b a=%h w=%b d=%h m=%h required 1 %h %b %h %h",
                               t, bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask, ea, ewen, ewd, ewm);
        end
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 4'b0000) begin
          failures++; $display("FAIL rand_req_quiet[%0d]: got %b required 0000", t,
                               {ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready});
        end
      end
      sw = $urandom_range(0, 3);
      for (int c = 0; c <= sw; c++) begin
        @(negedge clk);
        bus_req_ready = ($urandom_range(0, 1) == 1);
        flush = ($urandom_range(0, 5) == 0);
        rd = $urandom;
        err = ($urandom_range(0, 3) == 0);
        bus_resp_valid = (c == sw); bus_rdata = rd; bus_resp_err = err;
        if (flush && who == 1) dropped = 1'b1;
        #1;
        if (c < sw) begin
          checks++;
          if ({ifu_resp_valid, lsu_resp_valid, bus_req_valid} !== 3'b000) begin
            failures++; $display("FAIL rand_resp_wait[%0d]: got %b required 000", t,
                                 {ifu_resp_valid, lsu_resp_valid, bus_req_valid});
          end
        end else begin
          exp_iv = (who == 1) && !dropped;
          exp_lv = (who == 2);
          checks++;
          if ({ifu_resp_valid, lsu_resp_valid} !== {exp_iv, exp_lv}) begin
            failures++; $display("FAIL rand_route[%0d]: got %b required %b (dropped=%b)", t,
                                 {ifu_resp_valid, lsu_resp_valid}, {exp_iv, exp_lv}, dropped);
          end
          checks++;
          if (ifu_rdata !== (exp_iv ? rd : '0) || ifu_resp_err !== (exp_iv ? err : 1'b0) ||
              lsu_rdata !== (exp_lv ? rd : '0) || lsu_resp_err !== (exp_lv ? err : 1'b0)) begin
            failures++; $display("FAIL rand_rdata[%0d]: got i=%h/%b l=%h/%b bus=%h/%b route=%b%b", t,
                                 ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err, rd, err, exp_iv, exp_lv);
          end
        end
      end
    end
    @(negedge clk);
    drive_quiet();
  endtask

  task automatic test_reset_mid();
    int exp;
    // Run LSU-only transactions until the streak is saturated
    while (lsu_run < MAXS) begin
      @(negedge clk);
      lsu_req_valid = 1'b1; lsu_addr = 32'h0000_3000; lsu_wen = 1'b0;
      #1;
      checks++;
      if (lsu_req_ready !== 1'b1) begin
        failures++; $display("FAIL rmid_fill_grant: got %b required 1", lsu_req_ready);
      end
      note_grant(2);
      @(negedge clk);
      lsu_req_valid = 1'b0; bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
      @(negedge clk);
      bus_resp_valid = 1'b0;
    end
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_4000; lsu_wen = 1'b0;
    note_grant(2);
    @(negedge clk);
    lsu_req_valid = 1'b0; bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL rmid_pre: got v=%b d=%h required 1 cafef00d", lsu_resp_valid, lsu_rdata);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL rmid_async: got %h required 0", all_out);
    end
    @(negedge clk);
    reset = 1'b0;
    lsu_run = 0;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL rmid_release: got %h required 0", all_out);
    end
    @(negedge clk);
    bus_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0400;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_5000;
    #1;
    exp = pick(1'b1, 1'b1, 1'b0);
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== {exp == 1, exp == 2}) begin
      failures++; $display("FAIL rmid_streak_clear: got %b required %b", {ifu_req_ready, lsu_req_ready}, {exp == 1, exp == 2});
    end
    note_grant(exp);
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
    @(negedge clk);
    drive_quiet();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_fairness();
    test_flush_drop();
    test_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
